// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: single-cycle add/subtract, shift-add multiply and
// restoring divide (one bit per cycle), behind a start/busy/done handshake.
module seq_alu #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result,
    output logic           zero,
    output logic           div_zero
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] result_q, result_d;
    logic           zero_q, zero_d;
    logic           div_zero_q, div_zero_d;

    logic [N:0]     add_sum, sub_diff, mul_sum, div_sh, div_diff;
    logic [N-1:0]   hi_it, lo_it;
    logic           load;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        zero_d     = zero_q;
        div_zero_d = div_zero_q;
        load       = 1'b0;

        add_sum  = {1'b0, a} + {1'b0, b};
        sub_diff = {1'b0, a} - {1'b0, b};

        // hi holds the running partial product (MUL) or partial remainder (DIV);
        // lo holds the shifting multiplier (MUL) or dividend/quotient (DIV).
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(N+1){1'b0}});
        div_sh   = {hi_q, lo_q[N-1]};
        div_diff = div_sh - {1'b0, b_q};

        if (op_q == OP_MUL) begin
            {hi_it, lo_it} = {mul_sum, lo_q[N-1:1]};
        end else if (!div_diff[N]) begin
            hi_it = div_diff[N-1:0];
            lo_it = {lo_q[N-2:0], 1'b1};
        end else begin
            hi_it = div_sh[N-1:0];
            lo_it = {lo_q[N-2:0], 1'b0};
        end

        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start) begin
                    op_d  = op;
                    b_d   = b;
                    hi_d  = '0;
                    lo_d  = a;
                    cnt_d = CW'(N);
                    case (op)
                        OP_ADD: begin
                            result_d   = {{(N-1){1'b0}}, add_sum};
                            div_zero_d = 1'b0;
                            load       = 1'b1;
                            state_d    = FIN;
                        end
                        OP_SUB: begin
                            result_d   = {{(N-1){1'b0}}, sub_diff};
                            div_zero_d = 1'b0;
                            load       = 1'b1;
                            state_d    = FIN;
                        end
                        OP_MUL: state_d = RUN;
                        OP_DIV: begin
                            if (b == '0) begin
                                result_d   = {a, {N{1'b1}}};
                                div_zero_d = 1'b1;
                                load       = 1'b1;
                                state_d    = FIN;
                            end else begin
                                state_d = RUN;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            RUN: begin
                hi_d  = hi_it;
                lo_d  = lo_it;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    result_d   = {hi_it, lo_it};
                    div_zero_d = 1'b0;
                    load       = 1'b1;
                    state_d    = FIN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            zero_d = (result_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == FIN);
    assign result   = result_q;
    assign zero     = zero_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: the driver queues hand-computed results with
// their expected done cycle, and a monitor checks every done pulse against them.
module tb_seq_alu;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [1:0]     op = 2'b00;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*N-1:0] result;
    logic           zero;
    logic           div_zero;

    seq_alu #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        dz;
        int          when;
        string       name;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got result %0h want no done", result);
            end else begin
                e = sbq.pop_front();
                chk({e.name, "_result"}, 32'(result), 32'(e.res));
                chk({e.name, "_zero"}, 32'(zero), 32'(e.z));
                chk({e.name, "_div_zero"}, 32'(div_zero), 32'(e.dz));
                chk({e.name, "_done_cycle"}, cyc, e.when);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles, want 0", busy, n);
        end
    endtask

    // Drives one request from a negedge, queues the expectation after the
    // accepting edge, then drops start at the following negedge.
    task automatic issue(input string name, input logic [1:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [15:0] r, input logic z,
                         input logic dz, input int lat, input bit push);
        exp_t e;
        wait_idle();
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        if (push) begin
            e.res  = r;
            e.z    = z;
            e.dz   = dz;
            e.when = cyc + lat - 1;
            e.name = name;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    initial begin
        int d0;
        int n;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_zero", 32'(zero), 0);
        chk("rst_div_zero", 32'(div_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue("add200_100", 2'b00, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0, 1, 1'b1);
        issue("sub5_7",     2'b01, 8'd5,   8'd7,   16'h01FE, 1'b0, 1'b0, 1, 1'b1);
        issue("sub9_9",     2'b01, 8'd9,   8'd9,   16'h0000, 1'b1, 1'b0, 1, 1'b1);
        repeat (3) @(negedge clk);

        issue("mul255_255", 2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 9, 1'b1);
        chk("mul_busy_after_accept", 32'(busy), 1);
        repeat (3) begin
            start = 1'b1;
            op    = 2'b00;
            a     = 8'd1;
            b     = 8'd2;
            @(negedge clk);
        end
        start = 1'b0;

        issue("mul0_77",    2'b10, 8'd0,   8'd77,  16'h0000, 1'b1, 1'b0, 9, 1'b1);
        issue("div200_7",   2'b11, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 9, 1'b1);
        issue("div13_0",    2'b11, 8'd13,  8'd0,   16'h0DFF, 1'b0, 1'b1, 1, 1'b1);
        issue("add255_1",   2'b00, 8'd255, 8'd1,   16'h0100, 1'b0, 1'b0, 1, 1'b1);
        issue("mul13_11",   2'b10, 8'd13,  8'd11,  16'h008F, 1'b0, 1'b0, 9, 1'b1);
        issue("div255_16",  2'b11, 8'd255, 8'd16,  16'h0F0F, 1'b0, 1'b0, 9, 1'b1);

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 32'(sbq.size()), 0);
        repeat (2) @(negedge clk);

        d0 = done_cnt;
        issue("div_abort", 2'b11, 8'd200, 8'd7, 16'h0000, 1'b0, 1'b0, 9, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_result", 32'(result), 0);
        chk("abort_div_zero", 32'(div_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("no_done_after_abort", 32'(done_cnt), 32'(d0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
